// File: rtl/syncword_correlator_pkg.sv
// rtl/syncword_correlator_pkg.sv - shared constants and state encoding for the syncword correlator
package syncword_correlator_pkg;

    localparam int SYNC_LEN  = 64;
    localparam int MATCH_W   = 7;
    localparam int WIN_CNT_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } corr_state_e;

endpackage

// File: rtl/syncword_correlator_if.sv
// rtl/syncword_correlator_if.sv - bit stream, control, register and result signals of the correlator
interface syncword_correlator_if
    import syncword_correlator_pkg::*;
#(
    parameter int WIN_W = WIN_CNT_W
);
    logic                 p_1us;
    logic                 rxbit;
    logic                 corr_start_p;
    logic                 corr_abort;
    logic [SYNC_LEN-1:0]  regi_syncword;
    logic [MATCH_W-1:0]   regi_corr_threshold;
    logic [WIN_W-1:0]     regi_search_win;
    logic                 rx_trailer_st_p;
    logic                 sync_found;
    logic                 corr_timeout_p;
    logic [MATCH_W-1:0]   corr_peak;
    logic                 corr_busy;

    modport master (
        output p_1us, rxbit, corr_start_p, corr_abort,
        output regi_syncword, regi_corr_threshold, regi_search_win,
        input  rx_trailer_st_p, sync_found, corr_timeout_p, corr_peak, corr_busy
    );

    modport slave (
        input  p_1us, rxbit, corr_start_p, corr_abort,
        input  regi_syncword, regi_corr_threshold, regi_search_win,
        output rx_trailer_st_p, sync_found, corr_timeout_p, corr_peak, corr_busy
    );

endinterface

// File: rtl/syncword_correlator_popcount64.sv
// rtl/syncword_correlator_popcount64.sv - registered two-level adder tree counting ones in a 64-bit word
module popcount64
    import syncword_correlator_pkg::*;
(
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic [SYNC_LEN-1:0] data,
    output logic [MATCH_W-1:0]  count
);

    localparam int GROUPS = SYNC_LEN / 8;

    logic [3:0]         group_cnt [GROUPS];
    logic [MATCH_W-1:0] sum;

    // First level counts each byte, second level sums the byte counts.
    always_comb begin
        sum = '0;
        for (int g = 0; g < GROUPS; g++) begin
            group_cnt[g] = '0;
            for (int i = 0; i < 8; i++) begin
                group_cnt[g] = group_cnt[g] + {3'b000, data[g*8 + i]};
            end
            sum = sum + {3'b000, group_cnt[g]};
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            count <= '0;
        end else begin
            count <= sum;
        end
    end

endmodule

// File: rtl/syncword_correlator.sv
// rtl/syncword_correlator.sv - sliding 64-bit access-code correlator with threshold hit and search timeout
module syncword_correlator
    import syncword_correlator_pkg::*;
#(
    parameter int SW_LEN = SYNC_LEN,
    parameter int WIN_W  = WIN_CNT_W
) (
    input  logic                 clk_6M,
    input  logic                 rstz,
    syncword_correlator_if.slave bus
);

    localparam logic [MATCH_W-1:0] FILL_FULL = MATCH_W'(SW_LEN);
    localparam logic [WIN_W-1:0]   WIN_MAX   = '1;

    corr_state_e        state, state_d;
    logic [SW_LEN-1:0]  sr;
    logic [SW_LEN-1:0]  diff;
    logic [MATCH_W-1:0] fill;
    logic [MATCH_W-1:0] match;
    logic [WIN_W-1:0]   win_cnt;
    logic               v_shift, v_diff, v_match;
    logic               hit_pend;
    logic               sync_found_q, timeout_q;
    logic [MATCH_W-1:0] peak_q;
    logic               start_ok, flush;
    logic               shift_en, hit_dec, tmo_dec;

    assign start_ok = bus.corr_start_p & ~bus.corr_abort;
    assign flush    = bus.corr_abort | bus.corr_start_p;

    // Fill and window counters only move on strobes, so they still describe
    // the bit sitting in the decision stage three clocks later.
    always_comb begin
        state_d  = state;
        shift_en = 1'b0;
        hit_dec  = 1'b0;
        tmo_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (bus.corr_abort) begin
                    state_d = ST_IDLE;
                end else if (bus.corr_start_p) begin
                    state_d = ST_SEARCH;
                end else begin
                    shift_en = bus.p_1us;
                    hit_dec  = v_match && (fill == FILL_FULL) &&
                               (match >= bus.regi_corr_threshold);
                    tmo_dec  = v_match && !hit_dec && (bus.regi_search_win != '0) &&
                               (win_cnt == bus.regi_search_win);
                    if (hit_dec)      state_d = ST_LOCKED;
                    else if (tmo_dec) state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (bus.corr_abort)    state_d = ST_IDLE;
                else if (start_ok)     state_d = ST_SEARCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            sr           <= '0;
            diff         <= '0;
            fill         <= '0;
            win_cnt      <= '0;
            v_shift      <= 1'b0;
            v_diff       <= 1'b0;
            v_match      <= 1'b0;
            hit_pend     <= 1'b0;
            sync_found_q <= 1'b0;
            peak_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= tmo_dec;
            v_shift   <= shift_en;
            v_diff    <= v_shift & ~flush;
            v_match   <= v_diff & ~flush;
            diff      <= sr ^ bus.regi_syncword;

            if (shift_en) begin
                sr <= {sr[SW_LEN-2:0], bus.rxbit};
                if (fill != FILL_FULL) fill <= fill + 1'b1;
                if (win_cnt != WIN_MAX) win_cnt <= win_cnt + 1'b1;
            end else if (start_ok) begin
                sr      <= '0;
                fill    <= '0;
                win_cnt <= '0;
            end

            if (bus.corr_abort)   hit_pend <= 1'b0;
            else if (hit_dec)     hit_pend <= 1'b1;
            else if (bus.p_1us)   hit_pend <= 1'b0;

            if (start_ok) begin
                sync_found_q <= 1'b0;
                peak_q       <= '0;
            end else if (hit_dec) begin
                sync_found_q <= 1'b1;
                peak_q       <= match;
            end
        end
    end

    // Counting agreeing bits directly gives 64 - popcount(diff).
    popcount64 u_popcount (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .data   (~diff),
        .count  (match)
    );

    assign bus.rx_trailer_st_p = hit_pend & bus.p_1us;
    assign bus.sync_found      = sync_found_q;
    assign bus.corr_timeout_p  = timeout_q;
    assign bus.corr_peak       = peak_q;
    assign bus.corr_busy       = (state == ST_SEARCH);

endmodule

// File: tb/tb_syncword_correlator.sv
// tb/tb_syncword_correlator.sv - table, corner-case and randomized checks of syncword_correlator
module tb_syncword_correlator;
    import syncword_correlator_pkg::*;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;

    syncword_correlator_if bus_if ();

    syncword_correlator dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus_if)
    );

    always #5 clk_6M = ~clk_6M;

    typedef struct {
        logic [63:0] sw;
        int          thr;
        int          win;
        int          lead;
        int          flips;
        int          trail;
        int          exp_hit;
        int          exp_peak;
        int          exp_tmo;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    bit          stim[$];
    logic [63:0] cur_sw;
    int          cur_thr, cur_win;
    int          obs_trl_slot, obs_trl_cnt, obs_tmo_slot, obs_tmo_cnt;
    int          m_hit, m_peak, m_tmo;
    vec_t        vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bits are counted from the start pulse; a hit needs a full window of 64.
    function automatic void model(output int hit_bit, output int peak, output int tmo_bit);
        hit_bit = 0;
        peak    = 0;
        tmo_bit = 0;
        for (int k = 1; k <= stim.size(); k++) begin
            if (k >= 64) begin
                int agree;
                agree = 0;
                for (int i = 0; i < 64; i++) begin
                    if (stim[k-64+i] == cur_sw[63-i]) agree++;
                end
                if (agree >= cur_thr) begin
                    hit_bit = k;
                    peak    = agree;
                    return;
                end
            end
            if (cur_win != 0 && k == cur_win) begin
                tmo_bit = k;
                return;
            end
        end
    endfunction

    function automatic void build(input logic [63:0] sw, input int lead, input int flips, input int trail);
        logic [63:0] fmask;
        fmask = '0;
        for (int f = 0; f < flips; f++) fmask[(f*13) % 64] = 1'b1;
        stim.delete();
        for (int i = 0; i < lead; i++) stim.push_back(1'($urandom_range(0, 1)));
        for (int i = 63; i >= 0; i--) stim.push_back(sw[i] ^ fmask[i]);
        for (int i = 0; i < trail; i++) stim.push_back(1'($urandom_range(0, 1)));
    endfunction

    task automatic clear_obs();
        obs_trl_slot = 0;
        obs_trl_cnt  = 0;
        obs_tmo_slot = 0;
        obs_tmo_cnt  = 0;
    endtask

    task automatic slot(input bit b, input int slot_no, input int abort_at);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk_6M);
            bus_if.p_1us      = (j == 0);
            bus_if.rxbit      = (j == 0) ? b : 1'b0;
            bus_if.corr_abort = (j == abort_at);
            #1;
            if (bus_if.rx_trailer_st_p) begin
                obs_trl_cnt++;
                if (obs_trl_slot == 0) obs_trl_slot = slot_no;
            end
            if (bus_if.corr_timeout_p) begin
                obs_tmo_cnt++;
                if (obs_tmo_slot == 0) obs_tmo_slot = slot_no;
            end
        end
    endtask

    task automatic start_pulse();
        bus_if.regi_syncword       = cur_sw;
        bus_if.regi_corr_threshold = 7'(cur_thr);
        bus_if.regi_search_win     = 12'(cur_win);
        @(negedge clk_6M);
        bus_if.corr_start_p = 1'b1;
        bus_if.p_1us        = 1'b0;
        bus_if.corr_abort   = 1'b0;
        @(negedge clk_6M);
        bus_if.corr_start_p = 1'b0;
    endtask

    task automatic run_stream();
        clear_obs();
        start_pulse();
        for (int k = 1; k <= stim.size(); k++) slot(stim[k-1], k, -1);
    endtask

    task automatic check_run(input string tag, input int exp_hit, input int exp_peak, input int exp_tmo);
        check({tag, ".trailer_slot"}, obs_trl_slot, (exp_hit != 0) ? exp_hit + 1 : 0);
        check({tag, ".trailer_cnt"}, obs_trl_cnt, (exp_hit != 0) ? 1 : 0);
        check({tag, ".timeout_slot"}, obs_tmo_slot, exp_tmo);
        check({tag, ".timeout_cnt"}, obs_tmo_cnt, (exp_tmo != 0) ? 1 : 0);
        check({tag, ".sync_found"}, bus_if.sync_found, (exp_hit != 0) ? 1 : 0);
        check({tag, ".corr_peak"}, bus_if.corr_peak, exp_peak);
        check({tag, ".corr_busy"}, bus_if.corr_busy, (exp_hit != 0 || exp_tmo != 0) ? 0 : 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rx_trailer_st_p"}, bus_if.rx_trailer_st_p, 0);
        check({tag, ".sync_found"}, bus_if.sync_found, 0);
        check({tag, ".corr_timeout_p"}, bus_if.corr_timeout_p, 0);
        check({tag, ".corr_peak"}, bus_if.corr_peak, 0);
        check({tag, ".corr_busy"}, bus_if.corr_busy, 0);
    endtask

    initial begin
        bus_if.p_1us               = 1'b0;
        bus_if.rxbit               = 1'b0;
        bus_if.corr_start_p        = 1'b0;
        bus_if.corr_abort          = 1'b0;
        bus_if.regi_syncword       = '0;
        bus_if.regi_corr_threshold = '0;
        bus_if.regi_search_win     = '0;

        //           sw                      thr win  lead flips trail hit  peak tmo
        vecs[0] = '{64'hA5F0_1234_DEAD_BEEF, 64,  0,   10, 0,    2,    74,  64,  0};
        vecs[1] = '{64'hA5F0_1234_DEAD_BEEF, 61,  0,   10, 3,    2,    74,  61,  0};
        vecs[2] = '{64'hA5F0_1234_DEAD_BEEF, 61,  0,   10, 4,    2,    0,   0,   0};
        vecs[3] = '{64'hA5F0_1234_DEAD_BEEF, 64,  100, 100, 0,   0,    0,   0,   100};
        vecs[4] = '{64'hA5F0_1234_DEAD_BEEF, 64,  64,  0,  0,    2,    64,  64,  0};
        vecs[5] = '{64'h0123_4567_89AB_CDEF, 0,   0,   0,  5,    2,    64,  59,  0};

        repeat (3) @(negedge clk_6M);
        #1;
        check_all_zero("reset");
        @(negedge clk_6M);
        rstz = 1'b1;

        for (int v = 0; v < 6; v++) begin
            cur_sw  = vecs[v].sw;
            cur_thr = vecs[v].thr;
            cur_win = vecs[v].win;
            build(cur_sw, vecs[v].lead, vecs[v].flips, vecs[v].trail);
            run_stream();
            check_run($sformatf("vec%0d", v), vecs[v].exp_hit, vecs[v].exp_peak, vecs[v].exp_tmo);
        end

        // Abort together with start: abort wins, nothing is searched.
        cur_sw  = 64'hA5F0_1234_DEAD_BEEF;
        cur_thr = 64;
        cur_win = 0;
        @(negedge clk_6M);
        bus_if.corr_start_p = 1'b1;
        bus_if.corr_abort   = 1'b1;
        @(negedge clk_6M);
        bus_if.corr_start_p = 1'b0;
        bus_if.corr_abort   = 1'b0;
        #1;
        check("abort_start.busy", bus_if.corr_busy, 0);
        build(cur_sw, 0, 0, 2);
        clear_obs();
        for (int k = 1; k <= stim.size(); k++) slot(stim[k-1], k, -1);
        check("abort_start.trailer_cnt", obs_trl_cnt, 0);
        check("abort_start.busy_end", bus_if.corr_busy, 0);

        // Abort landing on the decision clock of the matching bit.
        build(cur_sw, 0, 0, 2);
        clear_obs();
        start_pulse();
        for (int k = 1; k <= 63; k++) slot(stim[k-1], k, -1);
        slot(stim[63], 64, 3);
        slot(stim[64], 65, -1);
        slot(stim[65], 66, -1);
        check("abort_dec.trailer_cnt", obs_trl_cnt, 0);
        check("abort_dec.busy", bus_if.corr_busy, 0);
        check("abort_dec.sync_found", bus_if.sync_found, 0);
        check("abort_dec.corr_peak", bus_if.corr_peak, 0);

        // Reset while a decided hit waits for its strobe.
        build(cur_sw, 0, 0, 2);
        clear_obs();
        start_pulse();
        for (int k = 1; k <= 64; k++) slot(stim[k-1], k, -1);
        check("rst_mid.sync_found_before", bus_if.sync_found, 1);
        @(negedge clk_6M);
        #2;
        rstz = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk_6M);
        rstz = 1'b1;
        slot(stim[64], 65, -1);
        slot(stim[65], 66, -1);
        check("rst_mid.trailer_cnt", obs_trl_cnt, 0);

        // Randomized searches against the window model.
        for (int r = 0; r < 10; r++) begin
            cur_sw  = {$urandom, $urandom};
            cur_thr = $urandom_range(56, 64);
            cur_win = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(40, 140);
            build(cur_sw, $urandom_range(0, 40), $urandom_range(0, 8), 3);
            model(m_hit, m_peak, m_tmo);
            run_stream();
            check_run($sformatf("rand%0d", r), m_hit, m_peak, m_tmo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
